// File: rtl/gpioemu_pkg.sv
// Shared register map and state encodings for the GPIO emulator bus master.
// The peripheral bench model imports the same address constants.
package gpioemu_pkg;

    localparam logic [15:0] ADDR_A1   = 16'h037F;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_A1,
        ST_WR_A2,
        ST_WR_START,
        ST_HOLDOFF,
        ST_POLL,
        ST_RD_W0,
        ST_RD_W1,
        ST_RD_L,
        ST_RESP
    } master_state_e;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_SETUP,
        XF_STROBE,
        XF_HOLD
    } xfer_phase_e;

endpackage

// File: rtl/gpioemu_bus_xfer.sv
// Single-access engine: SETUP, STROBE_CYCLES of strobe, HOLD. A new start is
// accepted in HOLD as well as IDLE so back-to-back accesses take 4 cycles each.
module gpioemu_bus_xfer
    import gpioemu_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start_i,
    input  logic        rnw_i,
    input  logic [15:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [15:0] saddress_o,
    output logic        swr_o,
    output logic        srd_o,
    output logic [31:0] sdata_wr_o,
    input  logic [31:0] sdata_rd_i
);

    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);

    xfer_phase_e phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rnw_q, rnw_d;
    logic        swr_q, swr_d;
    logic        srd_q, srd_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            phase_q <= XF_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rnw_q   <= 1'b0;
            swr_q   <= 1'b0;
            srd_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rnw_q   <= rnw_d;
            swr_q   <= swr_d;
            srd_q   <= srd_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rnw_d   = rnw_q;
        swr_d   = swr_q;
        srd_d   = srd_q;
        case (phase_q)
            XF_IDLE, XF_HOLD: begin
                if (start_i) begin
                    phase_d = XF_SETUP;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    rnw_d   = rnw_i;
                end else begin
                    phase_d = XF_IDLE;
                end
            end
            XF_SETUP: begin
                phase_d = XF_STROBE;
                cnt_d   = STROBE_LOAD;
                swr_d   = ~rnw_q;
                srd_d   = rnw_q;
            end
            XF_STROBE: begin
                if (cnt_q == 8'd0) begin
                    phase_d = XF_HOLD;
                    swr_d   = 1'b0;
                    srd_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: phase_d = XF_IDLE;
        endcase
    end

    // The caller captures read data on the edge that ends HOLD.
    assign done_o     = (phase_q == XF_HOLD);
    assign rdata_o    = sdata_rd_i;
    assign saddress_o = addr_q;
    assign swr_o      = swr_q;
    assign srd_o      = srd_q;
    assign sdata_wr_o = wdata_q;

endmodule

// File: rtl/gpioemu_bus_master.sv
// Host-side initiator: runs the write/start/poll/read sequence against the
// multiply/popcount peripheral and returns one response per accepted command.
//
// state       | meaning
// IDLE        | cmd_ready high, waiting for a command
// WR_A1       | writing operand A1
// WR_A2       | writing operand A2
// WR_START    | writing the control register to start the peripheral
// HOLDOFF     | idle wait before each status poll
// POLL        | reading status {ready,valid}
// RD_W0       | priming read of W (value discarded)
// RD_W1       | reading product W
// RD_L        | reading ones count L
// RESP        | rsp_valid pulse
module gpioemu_bus_master
    import gpioemu_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int POLL_HOLDOFF  = 8,
    parameter int POLL_LIMIT    = 64
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_ones,
    output logic        rsp_overflow,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] sdata_wr,
    input  logic [31:0] sdata_rd
);

    localparam logic [7:0] HOLDOFF_LOAD = 8'(POLL_HOLDOFF - 1);
    localparam logic [6:0] POLL_LIMIT_C = 7'(POLL_LIMIT);

    master_state_e state_q, state_d;
    logic [23:0] a1_q, a1_d, a2_q, a2_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [6:0]  poll_cnt_q, poll_cnt_d;
    logic        ovf_q, ovf_d;
    logic [31:0] w_q, w_d;
    logic [31:0] rsp_w_q, rsp_w_d;
    logic [23:0] rsp_ones_q, rsp_ones_d;
    logic        rsp_ovf_q, rsp_ovf_d;
    logic        rsp_to_q, rsp_to_d;

    logic        launch;
    logic        xfer_rnw;
    logic [15:0] xfer_addr;
    logic [31:0] xfer_wdata;
    logic        xfer_done;
    logic [31:0] xfer_rdata;

    gpioemu_bus_xfer #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_xfer (
        .clk       (clk),
        .n_reset   (n_reset),
        .start_i   (launch),
        .rnw_i     (xfer_rnw),
        .addr_i    (xfer_addr),
        .wdata_i   (xfer_wdata),
        .done_o    (xfer_done),
        .rdata_o   (xfer_rdata),
        .saddress_o(saddress),
        .swr_o     (swr),
        .srd_o     (srd),
        .sdata_wr_o(sdata_wr),
        .sdata_rd_i(sdata_rd)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            a1_q       <= '0;
            a2_q       <= '0;
            hold_cnt_q <= '0;
            poll_cnt_q <= '0;
            ovf_q      <= 1'b0;
            w_q        <= '0;
            rsp_w_q    <= '0;
            rsp_ones_q <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a1_q       <= a1_d;
            a2_q       <= a2_d;
            hold_cnt_q <= hold_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            ovf_q      <= ovf_d;
            w_q        <= w_d;
            rsp_w_q    <= rsp_w_d;
            rsp_ones_q <= rsp_ones_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_to_q   <= rsp_to_d;
        end
    end

    // Each access is launched on the edge that enters its state, so the bus
    // engine runs back-to-back with no idle cycle between accesses.
    always_comb begin
        state_d    = state_q;
        a1_d       = a1_q;
        a2_d       = a2_q;
        hold_cnt_d = hold_cnt_q;
        poll_cnt_d = poll_cnt_q;
        ovf_d      = ovf_q;
        w_d        = w_q;
        rsp_w_d    = rsp_w_q;
        rsp_ones_d = rsp_ones_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_to_d   = rsp_to_q;
        launch     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    a1_d       = cmd_a1;
                    a2_d       = cmd_a2;
                    poll_cnt_d = '0;
                    state_d    = ST_WR_A1;
                    launch     = 1'b1;
                end
            end
            ST_WR_A1: begin
                if (xfer_done) begin
                    state_d = ST_WR_A2;
                    launch  = 1'b1;
                end
            end
            ST_WR_A2: begin
                if (xfer_done) begin
                    state_d = ST_WR_START;
                    launch  = 1'b1;
                end
            end
            ST_WR_START: begin
                if (xfer_done) begin
                    state_d    = ST_HOLDOFF;
                    hold_cnt_d = HOLDOFF_LOAD;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == 8'd0) begin
                    state_d = ST_POLL;
                    launch  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            ST_POLL: begin
                if (xfer_done) begin
                    if (xfer_rdata[1]) begin
                        ovf_d   = ~xfer_rdata[0];
                        state_d = ST_RD_W0;
                        launch  = 1'b1;
                    end else if (poll_cnt_q + 7'd1 == POLL_LIMIT_C) begin
                        poll_cnt_d = poll_cnt_q + 7'd1;
                        rsp_w_d    = '0;
                        rsp_ones_d = '0;
                        rsp_ovf_d  = 1'b0;
                        rsp_to_d   = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 7'd1;
                        hold_cnt_d = HOLDOFF_LOAD;
                        state_d    = ST_HOLDOFF;
                    end
                end
            end
            ST_RD_W0: begin
                if (xfer_done) begin
                    state_d = ST_RD_W1;
                    launch  = 1'b1;
                end
            end
            ST_RD_W1: begin
                if (xfer_done) begin
                    w_d     = xfer_rdata;
                    state_d = ST_RD_L;
                    launch  = 1'b1;
                end
            end
            ST_RD_L: begin
                if (xfer_done) begin
                    rsp_w_d    = w_q;
                    rsp_ones_d = xfer_rdata[23:0];
                    rsp_ovf_d  = ovf_q;
                    rsp_to_d   = 1'b0;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        xfer_rnw   = 1'b1;
        xfer_addr  = '0;
        xfer_wdata = '0;
        case (state_d)
            ST_WR_A1: begin
                xfer_rnw   = 1'b0;
                xfer_addr  = ADDR_A1;
                xfer_wdata = {8'h00, a1_d};
            end
            ST_WR_A2: begin
                xfer_rnw   = 1'b0;
                xfer_addr  = ADDR_A2;
                xfer_wdata = {8'h00, a2_q};
            end
            ST_WR_START: begin
                xfer_rnw  = 1'b0;
                xfer_addr = ADDR_CTRL;
            end
            ST_POLL:            xfer_addr = ADDR_CTRL;
            ST_RD_W0, ST_RD_W1: xfer_addr = ADDR_W;
            ST_RD_L:            xfer_addr = ADDR_L;
            default:            xfer_addr = '0;
        endcase
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_w        = rsp_w_q;
    assign rsp_ones     = rsp_ones_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_timeout  = rsp_to_q;

endmodule

// File: tb/tb_gpioemu_bus_master.sv
// Directed bench for gpioemu_bus_master: peripheral model on the bus, response
// scoreboard, and a strobe protocol monitor.
module tb_gpioemu_bus_master;
    import gpioemu_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_a1, cmd_a2;
    logic        rsp_valid;
    logic [31:0] rsp_w;
    logic [23:0] rsp_ones;
    logic        rsp_overflow, rsp_timeout, busy;
    logic [15:0] saddress;
    logic        swr, srd;
    logic [31:0] sdata_wr;
    logic [31:0] sdata_rd = 32'h0;

    always #5 clk = ~clk;

    gpioemu_bus_master #(
        .STROBE_CYCLES(2),
        .POLL_HOLDOFF (8),
        .POLL_LIMIT   (64)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a1      (cmd_a1),
        .cmd_a2      (cmd_a2),
        .rsp_valid   (rsp_valid),
        .rsp_w       (rsp_w),
        .rsp_ones    (rsp_ones),
        .rsp_overflow(rsp_overflow),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .saddress    (saddress),
        .swr         (swr),
        .srd         (srd),
        .sdata_wr    (sdata_wr),
        .sdata_rd    (sdata_rd)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Peripheral model: W read path is two stages deep, L value is set per command.
    logic [23:0] p_a1 = '0, p_a2 = '0;
    logic [47:0] p_prod = '0;
    logic [31:0] w_stage = 32'hDEAD_BEEF;
    logic [23:0] l_val = '0;
    logic        rdy;
    int          p_polls = 0;
    int          status_reads = 0;
    int          ready_after = 1;
    bit          never_ready = 0;
    logic [15:0] wl_addr[$];
    logic [31:0] wl_data[$];

    always @(posedge swr) begin
        wl_addr.push_back(saddress);
        wl_data.push_back(sdata_wr);
        case (saddress)
            ADDR_A1:   p_a1 = sdata_wr[23:0];
            ADDR_A2:   p_a2 = sdata_wr[23:0];
            ADDR_CTRL: begin
                p_prod  = 48'(p_a1) * 48'(p_a2);
                p_polls = 0;
            end
            default: ;
        endcase
    end

    always @(posedge srd) begin
        case (saddress)
            ADDR_CTRL: begin
                status_reads++;
                p_polls++;
                rdy = !never_ready && (p_polls >= ready_after);
                sdata_rd = {30'h2AAA_AAAA, rdy, rdy & (p_prod[47:32] == 16'h0)};
            end
            ADDR_W: begin
                sdata_rd = w_stage;
                w_stage  = p_prod[31:0];
            end
            ADDR_L:  sdata_rd = {8'hA5, l_val};
            default: sdata_rd = 32'h0;
        endcase
    end

    typedef struct {
        logic [31:0] w;
        logic [23:0] ones;
        logic        ovf;
        logic        to;
    } rsp_t;

    rsp_t sb[$];
    int   hs_log[$];
    int   rsp_log[$];
    int   rsp_cnt = 0;
    logic        prev_strobe = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        rsp_t e;
        if (n_reset && cmd_valid && cmd_ready) hs_log.push_back(cyc);
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_log.push_back(cyc);
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_w", rsp_w, e.w);
                chk("rsp_ones", rsp_ones, e.ones);
                chk("rsp_overflow", rsp_overflow, e.ovf);
                chk("rsp_timeout", rsp_timeout, e.to);
            end
        end
        if (swr || srd) begin
            chk("strobe_excl", swr & srd, 0);
            if (prev_strobe) begin
                chk("addr_stable", saddress, prev_addr);
                chk("data_stable", sdata_wr, prev_data);
            end
        end
        prev_strobe = swr | srd;
        prev_addr   = saddress;
        prev_data   = sdata_wr;
    end

    task automatic send(input logic [23:0] a1, input logic [23:0] a2, input bit push, input rsp_t e);
        bit ok;
        @(posedge clk);
        #1;
        cmd_a1    = a1;
        cmd_a2    = a2;
        cmd_valid = 1'b1;
        if (push) sb.push_back(e);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        chk("handshake", ok, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_cnt >= target) begin
                ok = 1;
                break;
            end
        end
        chk("rsp_arrived", ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wb, sr, hb, rb, rc, n;
        bit ok;
        n_reset   = 1'b0;
        cmd_valid = 1'b0;
        cmd_a1    = '0;
        cmd_a2    = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_swr", swr, 0);
        chk("rst_srd", srd, 0);
        chk("rst_saddress", saddress, 0);
        chk("rst_sdata_wr", sdata_wr, 0);
        chk("rst_rsp_fields", {rsp_w, rsp_ones, rsp_overflow, rsp_timeout}, 0);
        n_reset = 1'b1;

        // 3 x 5: write sequence, first-poll latency, response
        ready_after = 1; never_ready = 0; l_val = 24'd2;
        wb = wl_addr.size(); sr = status_reads; hb = hs_log.size(); rb = rsp_log.size();
        send(24'd3, 24'd5, 1, '{32'd15, 24'd2, 1'b0, 1'b0});
        wait_rsp(1, 200);
        chk("wr_count", wl_addr.size() - wb, 3);
        chk("wr0_addr", wl_addr[wb], ADDR_A1);
        chk("wr0_data", wl_data[wb], 32'd3);
        chk("wr1_addr", wl_addr[wb+1], ADDR_A2);
        chk("wr1_data", wl_data[wb+1], 32'd5);
        chk("wr2_addr", wl_addr[wb+2], ADDR_CTRL);
        chk("wr2_data", wl_data[wb+2], 32'd0);
        chk("status_reads_1", status_reads - sr, 1);
        chk("latency_first_poll", rsp_log[rb] - hs_log[hb], 37);
        repeat (3) @(negedge clk);
        chk("rsp_pulse_len", rsp_valid, 0);
        chk("rsp_w_hold", rsp_w, 32'd15);
        chk("cmd_ready_after", cmd_ready, 1);

        // full-scale operands overflow
        l_val = 24'd8;
        send(24'hFFFFFF, 24'hFFFFFF, 1, '{32'hFE000001, 24'd8, 1'b1, 1'b0});
        wait_rsp(2, 200);

        // zero operand, exactly one response pulse
        l_val = 24'd0;
        rc = rsp_cnt;
        send(24'h123456, 24'd0, 1, '{32'd0, 24'd0, 1'b0, 1'b0});
        wait_rsp(rc + 1, 200);
        repeat (20) @(negedge clk);
        chk("single_pulse", rsp_cnt - rc, 1);

        // ready on the third poll
        ready_after = 3; l_val = 24'h00000B;
        sr = status_reads; hb = hs_log.size(); rb = rsp_log.size(); rc = rsp_cnt;
        send(24'd1000, 24'd1000, 1, '{32'h000F4240, 24'h00000B, 1'b0, 1'b0});
        wait_rsp(rc + 1, 300);
        chk("status_reads_3", status_reads - sr, 3);
        chk("latency_third_poll", rsp_log[rb] - hs_log[hb], 61);

        // never ready: poll limit then timeout
        never_ready = 1; l_val = 24'h00FFFF;
        sr = status_reads; rc = rsp_cnt;
        send(24'd7, 24'd9, 1, '{32'd0, 24'd0, 1'b0, 1'b1});
        wait_rsp(rc + 1, 2000);
        chk("status_reads_timeout", status_reads - sr, 64);

        // cmd_valid held across two commands
        never_ready = 0; ready_after = 1; l_val = 24'd5;
        hb = hs_log.size(); rb = rsp_log.size(); rc = rsp_cnt;
        sb.push_back('{32'h00020000, 24'd5, 1'b0, 1'b0});
        sb.push_back('{32'h00020000, 24'd5, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        cmd_a1 = 24'h000100; cmd_a2 = 24'h000200; cmd_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) n++;
            if (n == 2) break;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("held_handshakes", n, 2);
        wait_rsp(rc + 2, 200);
        chk("held_hs_logged", hs_log.size() - hb, 2);
        chk("held_second_hs_after_resp", hs_log[hb+1] - rsp_log[rb], 1);

        // reset during the write strobe of A2
        l_val = 24'd3;
        rc = rsp_cnt;
        send(24'd11, 24'd13, 0, '{32'd0, 24'd0, 1'b0, 1'b0});
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (swr && saddress == ADDR_A2) begin
                ok = 1;
                break;
            end
        end
        chk("saw_a2_strobe", ok, 1);
        n_reset = 1'b0;
        #1;
        chk("rst_mid_swr", swr, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_saddress", saddress, 0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        repeat (60) @(negedge clk);
        chk("rst_mid_no_rsp", rsp_cnt - rc, 0);
        chk("rst_mid_sb_empty", sb.size(), 0);
        send(24'd11, 24'd13, 1, '{32'd143, 24'd3, 1'b0, 1'b0});
        wait_rsp(rc + 1, 200);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
